// File: rtl/seq_divider.sv
// seq_divider
//   Iterative restoring divider for RV32M DIV / DIVU / REM / REMU. It sits beside
//   the single-cycle ALU in the execute stage. busy_o stalls the pipeline while a
//   division is in flight.
//
// Handshake:
//   start_i is sampled only in IDLE. An accepted start (start_i=1, flush_i=0)
//   raises busy_o in the next cycle. done_o is high for exactly one cycle, and
//   result_o is valid during that cycle. A start_i in the done_o cycle is ignored.
//   A start_i in the cycle after done_o is accepted. flush_i aborts the operation
//   in any state and suppresses done_o in the cycle where it is asserted.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   start_i    request a new operation (IDLE only)
//   flush_i    abort the operation in flight
//   op_i       00 DIV, 01 DIVU, 10 REM, 11 REMU (captured with start_i)
//   a_i, b_i   dividend / divisor (captured with start_i)
//   busy_o     high in CALC and FIN
//   done_o     single-cycle completion pulse
//   result_o   quotient or remainder; holds until the next done_o
//   state_o    FSM state (0 IDLE, 1 CALC, 2 FIN) for debug and checkers
//
// Parameters:
//   BITS_PER_CYCLE  quotient bits per CALC cycle (1, 2 or 4); N = 32/BITS_PER_CYCLE
//
// Optional feature (macro DIV_RESULT_CACHE_EN):
//   A one-entry cache holds the last completed operands and signedness, with
//   their quotient and remainder. A repeated request (for example DIV followed
//   by REM) is then answered from FIN one cycle after the start.

module seq_divider #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam int         N        = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_INIT = 5'(N - 1);

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] q_q;        // dividend shifting out / quotient shifting in
    logic [32:0] r_q;        // partial remainder
    logic [31:0] d_q;        // |divisor|
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        rem_sel_q;  // 1: REM/REMU result, 0: DIV/DIVU result
    logic [31:0] result_q;

    // ---------------- operand conditioning at capture ----------------
    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic        div_zero, sgn_ovf;
    logic        accept;

    assign signed_op = ~op_i[0];
    assign a_neg     = signed_op & a_i[31];
    assign b_neg     = signed_op & b_i[31];
    assign a_abs     = a_neg ? (~a_i + 32'd1) : a_i;
    assign b_abs     = b_neg ? (~b_i + 32'd1) : b_i;
    assign div_zero  = (b_i == 32'd0);
    assign sgn_ovf   = signed_op && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign accept    = (state_q == S_IDLE) && start_i && !flush_i;

    // ---------------- iteration datapath ----------------
    // The shifted remainder is widened to 34 bits so that the borrow of the
    // trial subtract lands in bit 33. The borrow decides whether the subtract is
    // kept or whether the shifted value is restored.
    logic [32:0] r_nx;
    logic [31:0] q_nx;
    logic [33:0] r_sh;
    logic [33:0] diff;

    always_comb begin
        r_nx = r_q;
        q_nx = q_q;
        r_sh = '0;
        diff = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r_sh = {r_nx, q_nx[31]};
            q_nx = {q_nx[30:0], 1'b0};
            diff = r_sh - {2'b00, d_q};
            if (!diff[33]) begin
                r_nx    = diff[32:0];
                q_nx[0] = 1'b1;
            end else begin
                r_nx = r_sh[32:0];
            end
        end
    end

    // ---------------- sign fix-up in FIN ----------------
    // Special cases and cache hits load final values with both sign flags
    // cleared, so FIN treats every path the same way.
    logic [31:0] quo_fin, rem_fin, fin_res;

    assign quo_fin = neg_quo_q ? (~q_q + 32'd1) : q_q;
    assign rem_fin = neg_rem_q ? (~r_q[31:0] + 32'd1) : r_q[31:0];
    assign fin_res = rem_sel_q ? rem_fin : quo_fin;

    // ---------------- optional result cache ----------------
    logic        cache_hit;
    logic [31:0] cache_quo, cache_rem;

`ifdef DIV_RESULT_CACHE_EN
    logic        cache_valid_q;
    logic        cache_signed_q;
    logic [31:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;
    logic        cap_signed_q;
    logic [31:0] cap_a_q, cap_b_q;

    assign cache_hit = cache_valid_q && (cache_a_q == a_i) && (cache_b_q == b_i)
                       && (cache_signed_q == signed_op);
    assign cache_quo = cache_quo_q;
    assign cache_rem = cache_rem_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
            cap_signed_q   <= 1'b0;
            cap_a_q        <= '0;
            cap_b_q        <= '0;
        end else begin
            if (accept) begin
                cap_signed_q <= signed_op;
                cap_a_q      <= a_i;
                cap_b_q      <= b_i;
            end
            if (state_q == S_FIN && !flush_i) begin
                cache_valid_q  <= 1'b1;
                cache_signed_q <= cap_signed_q;
                cache_a_q      <= cap_a_q;
                cache_b_q      <= cap_b_q;
                cache_quo_q    <= quo_fin;
                cache_rem_q    <= rem_fin;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_quo = '0;
    assign cache_rem = '0;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            q_q       <= '0;
            r_q       <= '0;
            d_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rem_sel_q <= op_i[1];
                        if (div_zero) begin
                            q_q       <= 32'hFFFF_FFFF;
                            r_q       <= {1'b0, a_i};
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= S_FIN;
                        end else if (sgn_ovf) begin
                            q_q       <= 32'h8000_0000;
                            r_q       <= '0;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= S_FIN;
                        end else if (cache_hit) begin
                            q_q       <= cache_quo;
                            r_q       <= {1'b0, cache_rem};
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= S_FIN;
                        end else begin
                            q_q       <= a_abs;
                            r_q       <= '0;
                            d_q       <= b_abs;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            cnt_q     <= CNT_INIT;
                            state_q   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        q_q <= q_nx;
                        r_q <= r_nx;
                        if (cnt_q == 5'd0) begin
                            state_q <= S_FIN;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                S_FIN: begin
                    if (!flush_i) begin
                        result_q <= fin_res;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // During FIN the new result is shown at once. result_q takes it at the end
    // of that cycle, so the value stays visible after done_o drops.
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_FIN) && !flush_i;
    assign result_o = done_o ? fin_res : result_q;
    assign state_o  = state_q;

endmodule
